// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks register-file indices 0..LAST_ADDR, presenting each
// register as one valid/ready beat on out_addr/out_data, and pulses done once
// the final beat has been accepted.
//
// Optional feature macro: REG_DUMP_CHECKSUM_EN
//   When defined, a running XOR of every accepted register beat is kept and
//   sent as one extra beat (out_addr=0, out_last=1) after the last register.
//   When undefined, the checksum register and the CSUM state are absent and
//   out_last marks the LAST_ADDR register beat.
//
// state | meaning
// IDLE  | waiting for start; busy low
// LOAD  | capture rf_rd_data for idx into the output registers
// SEND  | present register beat, hold it until out_ready
// CSUM  | present checksum beat, hold it until out_ready (checksum build only)
// DONE  | one-cycle done pulse, then back to IDLE

module reg_dump_reader #(
    parameter int LAST_ADDR = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rf_rd_addr,
    input  logic [31:0] rf_rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_addr,
    output logic [31:0] out_data,
    output logic        out_last
);

`ifdef REG_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, SEND, CSUM, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, SEND, DONE} state_t;
`endif

    localparam logic [4:0] LAST_IDX = 5'(LAST_ADDR);

    state_t      state;
    logic [4:0]  idx;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    // The register file is read combinationally at the current index.
    assign rf_rd_addr = idx;
    assign busy       = (state != IDLE);

    // Dump sequencer: index walk, output beat registers and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 5'd0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_addr  <= 5'd0;
            out_data  <= 32'd0;
`ifdef REG_DUMP_CHECKSUM_EN
            checksum  <= 32'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= 5'd0;
`ifdef REG_DUMP_CHECKSUM_EN
                        checksum <= 32'd0;
`endif
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    out_data  <= rf_rd_data;
                    out_addr  <= idx;
                    out_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                    out_last  <= 1'b0;
`else
                    out_last  <= (idx == LAST_IDX);
`endif
                    state     <= SEND;
                end
                SEND: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
                        checksum  <= checksum ^ out_data;
`endif
                        if (idx < LAST_IDX) begin
                            idx   <= idx + 5'd1;
                            state <= LOAD;
                        end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                            // The checksum beat goes out immediately; it already
                            // folds in the register beat accepted on this edge.
                            out_data  <= checksum ^ out_data;
                            out_addr  <= 5'd0;
                            out_last  <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= CSUM;
`else
                            done  <= 1'b1;
                            state <= DONE;
`endif
                        end
                    end
                end
`ifdef REG_DUMP_CHECKSUM_EN
                CSUM: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: stimulus pushes expected beats into a
// queue, independent monitors pop and compare on every accepted beat.
`timescale 1ns/1ps
module tb_reg_dump_reader;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst, start, out_ready;
    logic        busy, done, out_valid, out_last;
    logic [4:0]  rf_rd_addr, out_addr;
    logic [31:0] rf_rd_data, out_data;

    logic        start3, out_ready3;
    logic        busy3, done3, out_valid3, out_last3;
    logic [4:0]  rf_rd_addr3, out_addr3;
    logic [31:0] rf_rd_data3, out_data3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    beat_t q[$];
    beat_t q3[$];
    bit track_gap = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rf_val(input logic [4:0] a);
        return 32'(a) * 32'h11111111;
    endfunction

    function automatic logic [31:0] xor_upto(input int last);
        logic [31:0] x = 32'd0;
        for (int i = 0; i <= last; i++) x ^= rf_val(5'(i));
        return x;
    endfunction

    assign rf_rd_data  = rf_val(rf_rd_addr);
    assign rf_rd_data3 = rf_val(rf_rd_addr3);

    reg_dump_reader #(.LAST_ADDR(31)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_last(out_last)
    );

    reg_dump_reader #(.LAST_ADDR(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
        .rf_rd_addr(rf_rd_addr3), .rf_rd_data(rf_rd_data3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_addr(out_addr3), .out_data(out_data3), .out_last(out_last3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic push_dump();
        for (int i = 0; i <= 31; i++) begin
`ifdef REG_DUMP_CHECKSUM_EN
            q.push_back('{5'(i), rf_val(5'(i)), 1'b0});
`else
            q.push_back('{5'(i), rf_val(5'(i)), i == 31});
`endif
        end
`ifdef REG_DUMP_CHECKSUM_EN
        q.push_back('{5'd0, xor_upto(31), 1'b1});
`endif
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick(1);
            n++;
        end
        if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_beat(input logic [4:0] a, input int budget);
        int n = 0;
        while (!(out_valid && out_addr == a) && n < budget) begin
            tick(1);
            n++;
        end
        if (!(out_valid && out_addr == a)) chk("wait_beat_timeout", 32'(out_addr), 32'(a));
    endtask

    // Main DUT monitor: scoreboard pop, hold-while-stalled, done timing, beat spacing.
    bit    prev_acc_last = 0;
    bit    stall_prev = 0;
    beat_t stall_beat;
    int    last_acc_cyc = -1;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            prev_acc_last = 0;
            stall_prev    = 0;
            last_acc_cyc  = -1;
        end else begin
            chk("done_timing", 32'(done), 32'(prev_acc_last));
            if (stall_prev) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_addr", 32'(out_addr), 32'(stall_beat.addr));
                chk("hold_data", out_data, stall_beat.data);
                chk("hold_last", 32'(out_last), 32'(stall_beat.last));
            end
            stall_prev = out_valid && !out_ready;
            stall_beat = '{out_addr, out_data, out_last};
            prev_acc_last = 0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 32'(out_addr), 32'h0000dead);
                end else begin
                    e = q.pop_front();
                    chk("beat_addr", 32'(out_addr), 32'(e.addr));
                    chk("beat_data", out_data, e.data);
                    chk("beat_last", 32'(out_last), 32'(e.last));
                end
                if (track_gap && out_addr != 5'd0 && last_acc_cyc >= 0)
                    chk("beat_gap", 32'(cyc - last_acc_cyc), 32'd2);
                last_acc_cyc  = cyc;
                prev_acc_last = out_last;
            end
        end
    end

    // Short-dump DUT monitor: scoreboard pop and index bound.
    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            if (busy3) chk("idx3_range", 32'(rf_rd_addr3 <= 5'd3), 32'd1);
            if (out_valid3 && out_ready3) begin
                if (q3.size() == 0) begin
                    chk("unexpected_beat3", 32'(out_addr3), 32'h0000dead);
                end else begin
                    e = q3.pop_front();
                    chk("beat3_addr", 32'(out_addr3), 32'(e.addr));
                    chk("beat3_data", out_data3, e.data);
                    chk("beat3_last", 32'(out_last3), 32'(e.last));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        start3 = 1'b0; out_ready3 = 1'b1;
        tick(3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_addr", 32'(out_addr), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_rd_addr", 32'(rf_rd_addr), 32'd0);
        rst = 1'b0;
        tick(2);

        // Full dump with ready held high, start re-pulsed mid-dump and on done.
        track_gap = 1;
        push_dump();
        pulse_start();
        tick(6);
        chk("busy_during_dump", 32'(busy), 32'd1);
        pulse_start();
        wait_done("dump_a", 200);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        chk("start_at_done_ignored", 32'(busy), 32'd0);
        chk("dump_a_consumed", 32'(q.size()), 32'd0);
        track_gap = 0;

        // Backpressure on beat 7 for 5 cycles.
        push_dump();
        pulse_start();
        wait_beat(5'd7, 100);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("stall7_valid", 32'(out_valid), 32'd1);
            chk("stall7_addr", 32'(out_addr), 32'd7);
            chk("stall7_data", out_data, 32'h77777777);
        end
        out_ready = 1'b1;
        tick(1);
        chk("after_stall_busy", 32'(busy), 32'd1);
        wait_done("dump_b", 200);
        tick(2);
        chk("dump_b_consumed", 32'(q.size()), 32'd0);

        // Reset while waiting on beat 12.
        push_dump();
        pulse_start();
        wait_beat(5'd12, 100);
        out_ready = 1'b0;
        tick(2);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_addr", 32'(out_addr), 32'd0);
        chk("abort_data", out_data, 32'd0);
        chk("abort_last", 32'(out_last), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_rd_addr", 32'(rf_rd_addr), 32'd0);
        @(negedge clk);
        q.delete();
        tick(1);
        rst = 1'b0;
        out_ready = 1'b1;
        tick(4);
        chk("abort_idle", 32'(busy), 32'd0);

        // Fresh dump after the abort starts again at index 0.
        push_dump();
        pulse_start();
        wait_done("dump_d", 200);
        tick(2);
        chk("dump_d_consumed", 32'(q.size()), 32'd0);

        // Short dump instance, LAST_ADDR=3.
        for (int i = 0; i <= 3; i++) begin
`ifdef REG_DUMP_CHECKSUM_EN
            q3.push_back('{5'(i), rf_val(5'(i)), 1'b0});
`else
            q3.push_back('{5'(i), rf_val(5'(i)), i == 3});
`endif
        end
`ifdef REG_DUMP_CHECKSUM_EN
        q3.push_back('{5'd0, xor_upto(3), 1'b1});
`endif
        start3 = 1'b1;
        tick(1);
        start3 = 1'b0;
        begin
            int n = 0;
            while (!done3 && n < 50) begin
                tick(1);
                n++;
            end
            chk("dump3_done", 32'(done3), 32'd1);
        end
        tick(3);
        chk("dump3_consumed", 32'(q3.size()), 32'd0);
        chk("dump3_idle", 32'(busy3), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
